// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the six-digit multiplexed display scanner.
`include "seg_defs.vh"

package seg_scan_ctrl_pkg;

  localparam int          NUM_DIGITS = 6;
  localparam logic [5:0]  COM_OFF    = `SEG_COM_OFF;

  localparam logic [0:0]  ST_BLANK   = 1'b0;
  localparam logic [0:0]  ST_DRIVE   = 1'b1;

  // One full frame worth of display content.
  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dots;
  } frame_t;

endpackage

// File: rtl/bcd_segment.sv
// BCD to seven-segment decoder; non-decimal codes blank a-g but keep dp.
`include "seg_defs.vh"

module bcd_segment (
  input  logic [3:0] BCD,
  input  logic       DOT,
  output logic [7:0] SEG_DATA
);

  logic [6:0] seg;

  always_comb begin
    seg = `SEG_PAT_OFF;
    case (BCD)
      4'd0: seg = `SEG_PAT_0;
      4'd1: seg = `SEG_PAT_1;
      4'd2: seg = `SEG_PAT_2;
      4'd3: seg = `SEG_PAT_3;
      4'd4: seg = `SEG_PAT_4;
      4'd5: seg = `SEG_PAT_5;
      4'd6: seg = `SEG_PAT_6;
      4'd7: seg = `SEG_PAT_7;
      4'd8: seg = `SEG_PAT_8;
      4'd9: seg = `SEG_PAT_9;
      default: seg = `SEG_PAT_OFF;
    endcase
  end

  assign SEG_DATA = {seg, DOT};

endmodule

// File: rtl/seg_defs.vh
// Segment patterns {a,b,c,d,e,f,g}, the all-commons-off constant and default
// parameter values shared by the scan controller and its decoder.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH

`define SEG_SCAN_DIV_DEF     5000
`define SEG_BLANK_CYC_DEF    16
`define SEG_BLINK_FRAMES_DEF 64

`define SEG_COM_OFF 6'b111111

`define SEG_PAT_0   7'b1111110
`define SEG_PAT_1   7'b0110000
`define SEG_PAT_2   7'b1101101
`define SEG_PAT_3   7'b1111001
`define SEG_PAT_4   7'b0110011
`define SEG_PAT_5   7'b1011011
`define SEG_PAT_6   7'b1011111
`define SEG_PAT_7   7'b1110000
`define SEG_PAT_8   7'b1111111
`define SEG_PAT_9   7'b1111011
`define SEG_PAT_OFF 7'b0000000

`endif

// File: rtl/seg_scan_ctrl.sv
// Six-digit common-cathode style scanner: prescaled slots with anti-ghost blanking,
// frame-synchronous shadow load, per-digit blink and digit5 leading-zero blanking.
`include "seg_defs.vh"

module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = `SEG_SCAN_DIV_DEF,
  parameter int BLANK_CYC    = `SEG_BLANK_CYC_DEF,
  parameter int BLINK_FRAMES = `SEG_BLINK_FRAMES_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] DIGITS_IN,
  input  logic [5:0]  DOTS_IN,
  input  logic        LOAD,
  input  logic [5:0]  BLINK_EN,
  input  logic        LZB_EN,
  output logic [7:0]  SEG_DATA,
  output logic [5:0]  SEG_COM,
  output logic        LOAD_PEND,
  output logic        FRAME_DONE
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [0:0]    state_q, state_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  frame_t        pend_q, pend_d;
  frame_t        disp_q, disp_d;
  logic          load_pend_q, load_pend_d;
  logic          frame_done_q, frame_done_d;
  logic [5:0]    seg_com_q, seg_com_d;
  logic [7:0]    seg_data_q, seg_data_d;

  logic          tc, fb;
  logic [3:0]    nib;
  logic          dot, blk, lzb_hit;
  logic [7:0]    dec;

  // Slot timing, frame boundary and shadow transfer.
  always_comb begin
    tc      = (presc_q == PW'(SCAN_DIV - 1));
    fb      = tc && (idx_q == 3'd5);
    presc_d = tc ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (tc) idx_d = fb ? 3'd0 : idx_q + 3'd1;

    state_d = state_q;
    if (tc)                                   state_d = ST_BLANK;
    else if (presc_q == PW'(BLANK_CYC - 1))   state_d = ST_DRIVE;

    frm_d   = frm_q;
    phase_d = phase_q;
    if (fb) begin
      if (frm_q == FW'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    pend_d = pend_q;
    if (LOAD) begin
      pend_d.digits = DIGITS_IN;
      pend_d.dots   = DOTS_IN;
    end
    // Display only moves at the boundary, so a same-cycle LOAD lands a frame later.
    disp_d       = fb ? pend_q : disp_q;
    load_pend_d  = LOAD | (load_pend_q & ~fb);
    frame_done_d = fb;
  end

  always_comb begin
    nib = '0;
    dot = 1'b0;
    blk = 1'b0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (idx_q == 3'(n)) begin
        nib = disp_q.digits[4*n +: 4];
        dot = disp_q.dots[n];
        blk = BLINK_EN[n];
      end
    end
    lzb_hit = LZB_EN && (idx_q == 3'd5) && (nib == 4'd0);
  end

  bcd_segment u_dec (
    .BCD      (nib),
    .DOT      (dot),
    .SEG_DATA (dec)
  );

  always_comb begin
    seg_com_d  = COM_OFF;
    seg_data_d = '0;
    if (state_q == ST_DRIVE) begin
      seg_com_d = ~(6'b000001 << idx_q);
      if (!(phase_q && blk))
        seg_data_d = lzb_hit ? {7'b0, dot} : dec;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q      <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      pend_q       <= '0;
      disp_q       <= '0;
      load_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      seg_com_q    <= COM_OFF;
      seg_data_q   <= '0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      load_pend_q  <= load_pend_d;
      frame_done_q <= frame_done_d;
      seg_com_q    <= seg_com_d;
      seg_data_q   <= seg_data_d;
    end
  end

  assign SEG_DATA   = seg_data_q;
  assign SEG_COM    = seg_com_q;
  assign LOAD_PEND  = load_pend_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a small slot/frame timing setup.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] DIGITS_IN;
  logic [5:0]  DOTS_IN;
  logic        LOAD;
  logic [5:0]  BLINK_EN;
  logic        LZB_EN;
  logic [7:0]  SEG_DATA;
  logic [5:0]  SEG_COM;
  logic        LOAD_PEND;
  logic        FRAME_DONE;

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIGITS_IN  (DIGITS_IN),
    .DOTS_IN    (DOTS_IN),
    .LOAD       (LOAD),
    .BLINK_EN   (BLINK_EN),
    .LZB_EN     (LZB_EN),
    .SEG_DATA   (SEG_DATA),
    .SEG_COM    (SEG_COM),
    .LOAD_PEND  (LOAD_PEND),
    .FRAME_DONE (FRAME_DONE)
  );

  typedef struct packed {
    logic [5:0] com;
    logic [7:0] data;
    logic       lp;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [23:0] dig;
    logic [5:0]  dots;
    logic        lzb;
    int          idx;
    logic [7:0]  exp;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: time since reset plus shadow/display contents.
  int          m_t    = 0;
  logic [23:0] m_pend = '0;
  logic [23:0] m_disp = '0;
  logic [5:0]  m_pdot = '0;
  logic [5:0]  m_ddot = '0;
  logic        m_lp   = 1'b0;

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called with inputs settled before a rising edge; predicts and checks that edge.
  task automatic step();
    int pos, slot, phase;
    logic fb;
    logic [3:0] nib;
    exp_t e;
    pos   = m_t % SD;
    slot  = (m_t / SD) % 6;
    phase = ((m_t / (SD * 6)) / BF) % 2;
    fb    = (pos == SD - 1) && (slot == 5);
    if (RST) begin
      e = '{com: 6'h3f, data: 8'h00, lp: 1'b0, fd: 1'b0};
      m_t = 0; m_pend = '0; m_disp = '0; m_pdot = '0; m_ddot = '0; m_lp = 1'b0;
    end else begin
      nib = m_disp[slot*4 +: 4];
      if (pos < BC) begin
        e.com  = 6'h3f;
        e.data = 8'h00;
      end else begin
        e.com = ~(6'(1) << slot);
        if (phase == 1 && BLINK_EN[slot])
          e.data = 8'h00;
        else if (slot == 5 && LZB_EN && nib == 4'd0)
          e.data = {7'b0, m_ddot[slot]};
        else
          e.data = {pat(nib), m_ddot[slot]};
      end
      if (fb) begin
        m_disp = m_pend; m_ddot = m_pdot; m_lp = 1'b0;
      end
      if (LOAD) begin
        m_pend = DIGITS_IN; m_pdot = DOTS_IN; m_lp = 1'b1;
      end
      m_t++;
      e.lp = m_lp;
      e.fd = fb;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("sb_com",  32'(SEG_COM),    32'(e.com));
    chk("sb_data", 32'(SEG_DATA),   32'(e.data));
    chk("sb_lp",   32'(LOAD_PEND),  32'(e.lp));
    chk("sb_fd",   32'(FRAME_DONE), 32'(e.fd));
    @(negedge CLK);
  endtask

  task automatic seek(input int idx);
    logic [5:0] tgt;
    bit found;
    tgt   = ~(6'(1) << idx);
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step();
      if (SEG_COM === tgt) found = 1'b1;
    end
    chk($sformatf("seek_d%0d", idx), 32'(found), 32'd1);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] p);
    DIGITS_IN = d;
    DOTS_IN   = p;
    LOAD      = 1'b1;
    step();
    LOAD      = 1'b0;
  endtask

  vec_t       tv[9];
  logic [5:0] seq[16];
  int         nfd, dark0, lit0, dark2, guard;

  initial begin
    tv[0] = '{24'h123456, 6'b000000, 1'b0, 0, 8'hBE};
    tv[1] = '{24'h123456, 6'b000000, 1'b0, 5, 8'h60};
    tv[2] = '{24'h0A0000, 6'b100000, 1'b1, 5, 8'h01};
    tv[3] = '{24'h0A0000, 6'b100000, 1'b1, 4, 8'h00};
    tv[4] = '{24'h0A0000, 6'b100000, 1'b0, 5, 8'hFD};
    tv[5] = '{24'h789F00, 6'b000100, 1'b0, 2, 8'h01};
    tv[6] = '{24'h789F00, 6'b000100, 1'b0, 3, 8'hF6};
    tv[7] = '{24'h789F00, 6'b000100, 1'b0, 5, 8'hE0};
    tv[8] = '{24'h789F00, 6'b000100, 1'b0, 4, 8'hFE};
    seq   = '{6'h3f, 6'h3f, 6'h3e, 6'h3e, 6'h3e, 6'h3e, 6'h3e, 6'h3e,
              6'h3f, 6'h3f, 6'h3d, 6'h3d, 6'h3d, 6'h3d, 6'h3d, 6'h3d};

    RST = 1'b1; LOAD = 1'b0; DIGITS_IN = '0; DOTS_IN = '0; BLINK_EN = '0; LZB_EN = 1'b0;
    repeat (3) step();
    chk("rst_com",  32'(SEG_COM),    32'h3f);
    chk("rst_data", 32'(SEG_DATA),   32'h00);
    chk("rst_lp",   32'(LOAD_PEND),  32'h0);
    chk("rst_fd",   32'(FRAME_DONE), 32'h0);
    RST = 1'b0;

    // Scan order after release and frame pulse rate.
    nfd = 0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (i < 16) chk($sformatf("scan_seq%0d", i), 32'(SEG_COM), 32'(seq[i]));
      if (FRAME_DONE) nfd++;
    end
    chk("frame_done_count", 32'(nfd), 32'd2);

    // Mid-frame load: old display persists until the boundary.
    repeat (10) step();
    do_load(24'h123456, 6'b000000);
    chk("midload_lp", 32'(LOAD_PEND), 32'd1);
    seek(5);
    chk("midload_old_d5", 32'(SEG_DATA), 32'hFC);
    seek(0);
    chk("midload_new_d0", 32'(SEG_DATA), 32'hBE);

    for (int k = 0; k < 9; k++) begin
      LZB_EN = tv[k].lzb;
      do_load(tv[k].dig, tv[k].dots);
      repeat (60) step();
      seek(tv[k].idx);
      chk($sformatf("vec%0d_d%0d", k, tv[k].idx), 32'(SEG_DATA), 32'(tv[k].exp));
    end
    LZB_EN = 1'b0;

    // LOAD landing exactly on the frame boundary.
    do_load(24'h000001, 6'b000000);
    guard = 0;
    while ((m_t % (SD * 6)) != SD * 6 - 1 && guard < 100) begin
      step();
      guard++;
    end
    chk("bnd_reach", 32'(guard < 100), 32'd1);
    do_load(24'h999999, 6'b000000);
    chk("bnd_lp_hold", 32'(LOAD_PEND), 32'd1);
    seek(0);
    chk("bnd_old_d0", 32'(SEG_DATA), 32'h60);
    chk("bnd_lp_frame", 32'(LOAD_PEND), 32'd1);
    seek(5);
    seek(0);
    chk("bnd_new_d0", 32'(SEG_DATA), 32'hF6);
    chk("bnd_lp_clear", 32'(LOAD_PEND), 32'd0);

    // Blink on digits 0 and 1 only.
    do_load(24'h222222, 6'b000000);
    repeat (60) step();
    BLINK_EN = 6'b000011;
    dark0 = 0; lit0 = 0; dark2 = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (SEG_COM === 6'b111110) begin
        if (SEG_DATA == 8'h00) dark0++;
        else lit0++;
      end
      if (SEG_COM === 6'b111011 && SEG_DATA == 8'h00) dark2++;
    end
    chk("blink_dark_d0", 32'(dark0 > 0), 32'd1);
    chk("blink_lit_d0",  32'(lit0 > 0),  32'd1);
    chk("blink_d2_lit",  32'(dark2),     32'd0);
    BLINK_EN = 6'b000000;

    // Reset in the middle of digit3 drive, with a load still pending.
    seek(3);
    step();
    do_load(24'h777777, 6'b000000);
    RST = 1'b1;
    step();
    chk("mrst_com",  32'(SEG_COM),   32'h3f);
    chk("mrst_data", 32'(SEG_DATA),  32'h00);
    chk("mrst_lp",   32'(LOAD_PEND), 32'd0);
    RST = 1'b0;
    step();
    chk("mrst_b0", 32'(SEG_COM), 32'h3f);
    step();
    chk("mrst_b1", 32'(SEG_COM), 32'h3f);
    step();
    chk("mrst_d0_com",  32'(SEG_COM),  32'h3e);
    chk("mrst_d0_data", 32'(SEG_DATA), 32'hFC);
    repeat (100) step();
    seek(0);
    chk("mrst_discard", 32'(SEG_DATA), 32'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 5000, giving the clock cycles per digit slot (minimum 4).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, giving the anti-ghost blank cycles at the start of each slot (less than SCAN_DIV).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64, giving the frames per blink half-period.
REQ-004 The block SHALL have port CLK  in  1  system clock; one clock domain only.
REQ-005 The block SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port DIGITS_IN  in  24  six BCD nibbles; [3:0] is digit0 (rightmost), [23:20] is digit5.
REQ-007 The block SHALL have port DOTS_IN  in  6  decimal point per digit; bit n belongs to digit n.
REQ-008 The block SHALL have port LOAD  in  1  one-cycle strobe that captures DIGITS_IN and DOTS_IN.
REQ-009 The block SHALL have port BLINK_EN  in  6  per-digit blink enable.
REQ-010 The block SHALL have port LZB_EN  in  1  leading-zero blank enable for digit5.
REQ-011 The block SHALL have port SEG_DATA  out  8  {a,b,c,d,e,f,g,dp}, active-high.
REQ-012 The block SHALL have port SEG_COM  out  6  digit common lines, active-low, at most one low.
REQ-013 The block SHALL have port LOAD_PEND  out  1  high while captured data awaits transfer to the display.
REQ-014 The block SHALL have port FRAME_DONE  out  1  one-cycle pulse at the end of each slot 5.

Function
REQ-015 Prescaler: counts 0..SCAN_DIV-1 and wraps; the terminal count ends the slot and advances the digit index 0->1->...->5->0.
REQ-016 FSM state BLANK covers prescaler values 0..BLANK_CYC-1: SEG_COM=6'b111111 and SEG_DATA=0.
REQ-017 FSM state DRIVE covers prescaler values BLANK_CYC..SCAN_DIV-1: SEG_COM bit[index]=0, all other bits 1.
REQ-018 FSM transitions: BLANK->DRIVE when the prescaler reaches BLANK_CYC-1; DRIVE->BLANK at the terminal count.
REQ-019 In DRIVE, SEG_DATA SHALL equal the decode of display nibble[index] with dot = display dot[index].
REQ-020 Decode: values 0-9 give the standard a-g pattern, active-high; values 10-15 give all segments off with the dp bit still driven.
REQ-021 SEG_DATA and SEG_COM SHALL be registered, lagging the prescaler and FSM state by exactly 1 cycle.
REQ-022 LOAD=1 SHALL copy DIGITS_IN and DOTS_IN into a pending register and set LOAD_PEND on the next cycle.
REQ-023 Frame boundary = terminal count while index=5: pending copies to the display register, LOAD_PEND clears, and FRAME_DONE pulses on the next cycle.
REQ-024 LOAD on the frame-boundary cycle: the display register takes the old pending value, the pending register takes the new inputs, and LOAD_PEND stays 1.
REQ-025 Back-to-back LOADs: the last one before a boundary wins; no queuing.
REQ-026 Blink: a frame counter 0..BLINK_FRAMES-1 toggles the blink phase on wrap; while phase=1, digits with BLINK_EN[n]=1 show SEG_DATA=0 in DRIVE, with SEG_COM still asserted.
REQ-027 BLINK_EN SHALL be sampled live, not shadowed.
REQ-028 LZB: when LZB_EN=1 and display nibble5=0, digit5 segments a-g SHALL be 0 while dp follows dot5.
REQ-029 The display register SHALL never change mid-frame, so no torn frames occur.

Reset
REQ-030 RST=1 at a clock edge SHALL force: prescaler 0, index 0, state BLANK, frame and blink counters 0, blink phase 0.
REQ-031 RST=1 at a clock edge SHALL also force: pending and display registers 0, LOAD_PEND=0, FRAME_DONE=0, SEG_COM=6'b111111, SEG_DATA=8'h00.
REQ-032 RST asserted mid-slot or mid-frame SHALL abort the slot; after release, scanning restarts at digit0 in BLANK, and a pending LOAD is discarded.
REQ-033 RST SHALL take priority over LOAD.

Structure
REQ-034 The segment patterns, the SEG_COM all-off constant and the default parameter values SHALL live in shared include file seg_defs.vh.
REQ-035 The digit decode SHALL be the single sub-module bcd_segment (BCD, DOT -> SEG_DATA), instantiated once on the muxed nibble.
REQ-036 The prescaler, FSM, shadow registers, blink logic and output registers SHALL all be inside seg_scan_ctrl.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-037 After reset release: SEG_COM sequence 111111 x2 cycles, then 111110 x6, then 111111 x2, then 111101 x6, and so on up to digit5; FRAME_DONE pulses once every 48 cycles.
REQ-038 LOAD with DIGITS_IN=24'h123456 mid-frame: LOAD_PEND rises, the display keeps the old value until the boundary, then digit0 shows 8'b1011_1110 (6) and digit5 shows 8'b0110_0000 (1).
REQ-039 LOAD on the boundary cycle with a prior pending value of 24'h000001: the display shows ...01 and LOAD_PEND remains 1 for one more frame.
REQ-040 DIGITS_IN=24'h0A0000 with LZB_EN=1 and DOTS_IN=6'b100000: digit5 shows 8'h01, and digit4 shows 8'h00 (invalid nibble A).
REQ-041 BLINK_EN=6'b000011: digits 0-1 dark during alternate 2-frame periods, other digits unaffected.
REQ-042 RST pulsed during the digit3 DRIVE slot: the next cycle has SEG_COM=111111 and SEG_DATA=0, and the scan resumes at digit0.
